// File: rtl/opl_slot_rmw_sequencer_if.sv
// Memory-port and datapath handshake bundle for opl_slot_rmw_sequencer.
// master = sequencer side, slave = memory bank plus operator datapath.
interface opl_slot_rmw_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 36
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  mem_wea;
  logic [AW-1:0]         mem_addra;
  logic [DATA_WIDTH-1:0] mem_dia;
  logic                  mem_reb;
  logic [AW-1:0]         mem_addrb;
  logic [DATA_WIDTH-1:0] mem_dob;
  logic                  slot_valid;
  logic [AW-1:0]         slot_num;
  logic [DATA_WIDTH-1:0] slot_state;
  logic                  upd_valid;
  logic [DATA_WIDTH-1:0] upd_data;

  modport master (
    output mem_wea, mem_addra, mem_dia, mem_reb, mem_addrb,
    output slot_valid, slot_num, slot_state,
    input  mem_dob, upd_valid, upd_data
  );

  modport slave (
    input  mem_wea, mem_addra, mem_dia, mem_reb, mem_addrb,
    input  slot_valid, slot_num, slot_state,
    output mem_dob, upd_valid, upd_data
  );
endinterface

// File: rtl/opl_slot_rmw_sequencer.sv
// Per-sample read-modify-write sweep over the slot state bank (RD -> WAIT -> EMIT -> WB).
// Define OPL_SLOT_RMW_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is tied low.
module opl_slot_rmw_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 36,
  parameter int OUTPUT_DELAY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_clk_en,
  output logic busy,
  output logic sweep_done,
  output logic overrun,
  opl_slot_rmw_sequencer_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [1:0]    WAIT_LAST = 2'((OUTPUT_DELAY > 0) ? OUTPUT_DELAY - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EMIT, S_WB} state_t;

  state_t                state_reg, state_next;
  logic [AW-1:0]         slot_reg, slot_next;
  logic [1:0]            wait_reg, wait_next;
  logic [DATA_WIDTH-1:0] slot_state_next;
  logic [DATA_WIDTH-1:0] dia_next;
  logic                  done_next;
  logic                  can_start;

  // The sweep_done cycle is still treated as busy for start-strobe purposes.
  assign can_start = (state_reg == S_IDLE) && !sweep_done;

  always_comb begin
    state_next      = state_reg;
    slot_next       = slot_reg;
    wait_next       = wait_reg;
    slot_state_next = bus.slot_state;
    dia_next        = bus.mem_dia;
    done_next       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (sample_clk_en && can_start) begin
          state_next = S_RD;
          slot_next  = '0;
        end
      end
      S_RD: begin
        wait_next = '0;
        if (OUTPUT_DELAY == 0) begin
          state_next      = S_EMIT;
          slot_state_next = bus.mem_dob;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_reg == WAIT_LAST) begin
          state_next      = S_EMIT;
          slot_state_next = bus.mem_dob;
          wait_next       = '0;
        end else begin
          wait_next = wait_reg + 2'd1;
        end
      end
      S_EMIT: begin
        if (bus.upd_valid) begin
          dia_next   = bus.upd_data;
          state_next = S_WB;
        end
      end
      S_WB: begin
        if (slot_reg == LAST_SLOT) begin
          slot_next  = '0;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          slot_next  = slot_reg + AW'(1);
          state_next = S_RD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Every output is a flop fed from the next-state decode so it lines up with the state it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      slot_reg       <= '0;
      wait_reg       <= '0;
      busy           <= 1'b0;
      sweep_done     <= 1'b0;
      bus.mem_wea    <= 1'b0;
      bus.mem_addra  <= '0;
      bus.mem_dia    <= '0;
      bus.mem_reb    <= 1'b0;
      bus.mem_addrb  <= '0;
      bus.slot_valid <= 1'b0;
      bus.slot_num   <= '0;
      bus.slot_state <= '0;
    end else begin
      state_reg      <= state_next;
      slot_reg       <= slot_next;
      wait_reg       <= wait_next;
      busy           <= (state_next != S_IDLE);
      sweep_done     <= done_next;
      bus.mem_wea    <= (state_next == S_WB);
      bus.mem_addra  <= slot_next;
      bus.mem_dia    <= dia_next;
      bus.mem_reb    <= (state_next == S_RD);
      bus.mem_addrb  <= slot_next;
      bus.slot_valid <= (state_next == S_EMIT);
      bus.slot_num   <= slot_next;
      bus.slot_state <= slot_state_next;
    end
  end

`ifdef OPL_SLOT_RMW_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (sample_clk_en && !can_start) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: doc/opl_slot_rmw_sequencer.md
# opl_slot_rmw_sequencer

Read-modify-write client for a single-bank per-slot state memory: on each sample tick it sweeps slots 0..DEPTH-1, reads each slot's state through the memory read port, and hands that state to the operator datapath. It then accepts the updated state back and writes it to the same address. It sits between the sample-rate timing generator and the operator/envelope pipeline. It owns both memory ports, so no other agent touches the bank during a sweep.

## Interface
- DATA_WIDTH, 32, width of one slot state word
- DEPTH, 36, number of slots; address width AW = $clog2(DEPTH)
- OUTPUT_DELAY, 1, read latency of the attached memory in clocks (0, 1 or 2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_clk_en  in  1  one-cycle sweep start strobe
- busy  out  1  high from the first RD cycle through the last WB cycle
- sweep_done  out  1  one-cycle pulse after the final slot's write-back
- mem_wea  out  1  memory write enable
- mem_addra  out  AW  memory write address
- mem_dia  out  DATA_WIDTH  memory write data
- mem_reb  out  1  memory read enable
- mem_addrb  out  AW  memory read address
- mem_dob  in  DATA_WIDTH  memory read data
- slot_valid  out  1  slot_state/slot_num valid for the datapath
- slot_num  out  AW  slot being presented
- slot_state  out  DATA_WIDTH  state word read for slot_num
- upd_valid  in  1  datapath returns updated state
- upd_data  in  DATA_WIDTH  updated state word
- overrun  out  1  sticky: a sweep start arrived while busy

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets slot counter = 0, state = IDLE and the wait counter = 0. Memory contents are not touched.
- FSM states:
  - IDLE: on sample_clk_en go to RD with slot = 0. Otherwise stay.
  - RD: mem_reb = 1, mem_addrb = slot, for 1 cycle. If OUTPUT_DELAY = 0, capture mem_dob into slot_state at the end of RD and go to EMIT. Otherwise go to WAIT.
  - WAIT: hold for OUTPUT_DELAY cycles with mem_reb = 0. Capture mem_dob at the end of the last WAIT cycle, then go to EMIT.
  - EMIT: slot_valid = 1, slot_num = slot, slot_state held stable. Stay until upd_valid = 1, then latch upd_data and go to WB.
  - WB: mem_wea = 1, mem_addra = slot, mem_dia = latched upd_data, for 1 cycle. If slot == DEPTH-1, pulse sweep_done, reset slot to 0 and go to IDLE. Otherwise increment slot and go to RD.
- Slot counter wraps only via the DEPTH-1 check; it never reaches DEPTH.
- upd_valid outside EMIT is ignored. slot_valid drops in the cycle after acceptance.
- sample_clk_en when not in IDLE (including the sweep_done cycle) does not start a sweep and sets overrun. overrun clears only on reset.
- mem_reb and mem_wea are never high in the same cycle. Write-back of slot k completes before the read of slot k+1, so no forwarding is needed.

## Timing
- Strobe sampled at edge t: RD occupies cycle t+1, and slot_valid rises at t+2+OUTPUT_DELAY.
- Per slot: 3 + OUTPUT_DELAY + E cycles, where E = extra EMIT cycles waited for upd_valid (E = 0 when upd_valid is already high on entry).
- Minimum sweep: DEPTH × (3 + OUTPUT_DELAY) cycles. sweep_done is asserted in the cycle after the last WB.
- busy is 1 from RD of slot 0 through WB of slot DEPTH-1, and 0 in the sweep_done cycle.
- Asynchronous reset mid-sweep: outputs go to 0 immediately and the sweep is abandoned. A partially written sweep is acceptable; no write is in flight after reset.

## Configuration
- OPL_SLOT_RMW_OVERRUN_EN defined: overrun behaves as specified above.
- Undefined: overrun is tied to 0, with no sticky flop. A start strobe while busy is still ignored.

## Test plan
- DEPTH=4, OUTPUT_DELAY=1, memory preloaded with 0x10,0x11,0x12,0x13, datapath returns state+1 with upd_valid held high:
  - slot_valid first rises 3 cycles after the strobe.
  - sweep_done arrives 16 cycles after RD of slot 0.
  - Memory ends as 0x11..0x14.
- OUTPUT_DELAY 0 and 2, same stimulus: per-slot period of 3 and 5 cycles respectively; identical final memory.
- Datapath stalls upd_valid 4 cycles on slot 2: slot_state stays 0x12 and slot_valid stays high through the stall. The slot 2 write occurs exactly 1 cycle after upd_valid.
- sample_clk_en pulsed mid-sweep:
  - No second sweep starts.
  - overrun = 1 and stays 1 after sweep_done.
  - With the macro undefined, overrun stays 0.
- reset_n asserted during EMIT of slot 1:
  - All outputs read 0 asynchronously.
  - After release plus a strobe, the sweep restarts at slot 0.
- Throughout all tests, mem_wea & mem_reb is never 1 and mem_addra is never ≥ DEPTH.
